uart_cmd_wrapper: RTL and testbench

- Receives the serial command stream from the remote and assembles 3-byte packets: command opcode, data high byte, data low byte.
- Presents each completed packet as cmd/data with a cmd_rdy flag to the command-configuration stage directly downstream.
- cmd_rdy is held until that stage pulses clr_cmd_rdy.
- Contains the bit-level 8N1 receiver plus the packet-assembly state machine and an inter-byte timeout.

---
 rtl/uart_cmd_pkg.sv | 25 ++
 rtl/uart_rx.sv | 88 ++++++++
 rtl/uart_cmd_wrapper.sv | 103 ++++++++++
 tb/tb_uart_cmd_wrapper.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command path.
package uart_cmd_pkg;

  // Frame length: start + 8 data + stop.
  localparam int RX_BITS   = 10;
  // Bytes per command packet: opcode, data high, data low.
  localparam int PKT_BYTES = 3;

  // Packet-assembly states, one per expected byte.
  typedef enum logic [1:0] {
    CMD_BYTE = 2'd0,
    HI_BYTE  = 2'd1,
    LO_BYTE  = 2'd2
  } asm_state_t;

  // Opcodes understood by the downstream command stage.
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

endpackage

// File: rtl/uart_rx.sv
// 8N1 bit-level receiver: synchronizer, baud timing, 10-bit frame capture.
module uart_rx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data
);

  localparam int                BAUD_W    = $clog2(BAUD_CYCLES + 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(BAUD_CYCLES);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_CYCLES / 2);
  localparam int                BIT_W     = $clog2(RX_BITS + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RX_BITS);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  logic               r_rx_ff1;
  logic               r_rx_ff2;
  rx_state_t          r_state;
  logic [BAUD_W-1:0]  r_baud_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [RX_BITS-1:0] r_shift;
  logic               r_rdy;
  logic [7:0]         r_rx_data;
  // The start-bit slot falls out of the shift register and is never needed.
  logic               w_unused_start;

  assign w_unused_start = r_shift[0];
  assign rdy            = r_rdy;
  assign rx_data        = r_rx_data;

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ff1 <= 1'b1;
      r_rx_ff2 <= 1'b1;
    end else begin
      r_rx_ff1 <= RX;
      r_rx_ff2 <= r_rx_ff1;
    end
  end

  // Frame receiver: half-bit delay to mid start bit, then one sample per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RX_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rdy      <= 1'b0;
      r_rx_data  <= 8'h00;
    end else begin
      if (clr_rdy) r_rdy <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!r_rx_ff2) begin
            r_state    <= RX_RECV;
            r_baud_cnt <= BAUD_HALF;
            r_bit_cnt  <= '0;
            r_rdy      <= 1'b0;
          end
        end
        RX_RECV: begin
          if (r_bit_cnt == BIT_LAST) begin
            // Stop bit is not qualified; a framing error still delivers a byte.
            r_rx_data <= r_shift[8:1];
            r_rdy     <= 1'b1;
            r_state   <= RX_IDLE;
          end else if (r_baud_cnt == '0) begin
            r_shift    <= {r_rx_ff2, r_shift[RX_BITS-1:1]};
            r_baud_cnt <= BAUD_FULL;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles 3-byte command packets from the UART byte stream.
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_CYCLES = 2604,
  parameter int FAST_SIM    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data
);

  localparam int TO_W = (FAST_SIM != 0) ? 10 : 22;

  logic            w_rx_rdy;
  logic [7:0]      w_rx_data;
  logic            w_clr_rx_rdy;
  logic            w_timeout;

  asm_state_t      r_state;
  logic [7:0]      r_cmd_shadow;
  logic [7:0]      r_hi_shadow;
  logic [7:0]      r_cmd;
  logic [15:0]     r_data;
  logic            r_cmd_rdy;
  logic [TO_W-1:0] r_timeout;

  // Every state consumes a byte the cycle it appears, so the ack is rx_rdy itself.
  assign w_clr_rx_rdy = w_rx_rdy;
  assign w_timeout    = &r_timeout;
  assign cmd_rdy      = r_cmd_rdy;
  assign cmd          = r_cmd;
  assign data         = r_data;

  uart_rx #(
    .BAUD_CYCLES(BAUD_CYCLES)
  ) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(w_clr_rx_rdy),
    .rdy    (w_rx_rdy),
    .rx_data(w_rx_data)
  );

  // Packet assembly, inter-byte timeout and registered packet outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CMD_BYTE;
      r_cmd_shadow <= 8'h00;
      r_hi_shadow  <= 8'h00;
      r_cmd        <= 8'h00;
      r_data       <= 16'h0000;
      r_cmd_rdy    <= 1'b0;
      r_timeout    <= '0;
    end else begin
      // Default clear; a packet load below overrides it in the same cycle.
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      case (r_state)
        CMD_BYTE: begin
          r_timeout <= '0;
          if (w_rx_rdy) begin
            r_cmd_shadow <= w_rx_data;
            r_cmd_rdy    <= 1'b0;   // new packet starts: drop any stale one
            r_state      <= HI_BYTE;
          end
        end
        HI_BYTE: begin
          if (w_rx_rdy) begin
            r_hi_shadow <= w_rx_data;
            r_timeout   <= '0;
            r_state     <= LO_BYTE;
          end else if (w_timeout) begin
            r_timeout <= '0;
            r_state   <= CMD_BYTE;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end
        LO_BYTE: begin
          if (w_rx_rdy) begin
            r_cmd     <= r_cmd_shadow;
            r_data    <= {r_hi_shadow, w_rx_data};
            r_cmd_rdy <= 1'b1;
            r_timeout <= '0;
            r_state   <= CMD_BYTE;
          end else if (w_timeout) begin
            r_timeout <= '0;
            r_state   <= CMD_BYTE;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end
        default: r_state <= CMD_BYTE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper with BAUD_CYCLES = 32.
module tb_uart_cmd_wrapper;

  localparam int BAUD = 32;
  localparam int BYTE_CYC = 10 * BAUD;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;

  int errors = 0;
  int checks = 0;

  // Monitor state
  int          cyc = 0;
  int          rx_rise_cyc = 0;
  int          cmd_rise_cyc = 0;
  logic        prev_rx_rdy = 1'b0;
  logic        prev_cmd_rdy = 1'b0;
  logic        saw_cmd04 = 1'b0;
  logic [23:0] pkt_q[$];

  uart_cmd_wrapper #(
    .BAUD_CYCLES(BAUD),
    .FAST_SIM   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drives one 8N1 frame from a negedge; optional clr pulse at cycle clr_at; ncyc < 320 aborts early.
  task automatic send_byte(input logic [7:0] b, input int clr_at, input int ncyc);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      if (c % BAUD == 0) RX = frame[c / BAUD];
      clr_cmd_rdy = (c == clr_at);
      @(negedge clk);
    end
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, -1, BYTE_CYC);
    send_byte(b1, -1, BYTE_CYC);
    send_byte(b2, -1, BYTE_CYC);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // Records rx_rdy / cmd_rdy rise cycles and every presented packet.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (dut.w_rx_rdy && !prev_rx_rdy) rx_rise_cyc = cyc;
      if (cmd_rdy && !prev_cmd_rdy) begin
        cmd_rise_cyc = cyc;
        pkt_q.push_back({cmd, data});
        if (cmd == 8'h04) saw_cmd04 = 1'b1;
      end
      prev_rx_rdy  = dut.w_rx_rdy;
      prev_cmd_rdy = cmd_rdy;
    end
  end

  initial begin
    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("reset_cmd", {24'd0, cmd}, 32'h00);
    check("reset_data", {16'd0, data}, 32'h0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic packet, hold and consume
    send_pkt(8'h02, 8'h12, 8'h34);
    repeat (2) @(negedge clk);
    check("p1_cmd", {24'd0, cmd}, 32'h02);
    check("p1_data", {16'd0, data}, 32'h1234);
    check("p1_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("p1_latency", cmd_rise_cyc - rx_rise_cyc, 32'd1);
    repeat (10) @(negedge clk);
    check("p1_hold", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr();
    check("p1_clr_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("p1_clr_cmd", {24'd0, cmd}, 32'h02);
    check("p1_clr_data", {16'd0, data}, 32'h1234);
    pulse_clr();
    check("p1_clr_idle_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("p1_clr_idle_data", {16'd0, data}, 32'h1234);

    // Back-to-back packets, no consume
    pkt_q.delete();
    send_pkt(8'h05, 8'h01, 8'hFF);
    check("b2b_first_rdy", {31'd0, cmd_rdy}, 32'd1);
    send_byte(8'h03, -1, BYTE_CYC);
    check("b2b_drop_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("b2b_drop_cmd", {24'd0, cmd}, 32'h05);
    send_byte(8'h80, -1, BYTE_CYC);
    send_byte(8'h00, -1, BYTE_CYC);
    repeat (2) @(negedge clk);
    check("b2b_count", pkt_q.size(), 32'd2);
    if (pkt_q.size() >= 2) begin
      check("b2b_pkt0", {8'd0, pkt_q[0]}, 32'h0501FF);
      check("b2b_pkt1", {8'd0, pkt_q[1]}, 32'h038000);
    end
    check("b2b_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("b2b_latency", cmd_rise_cyc - rx_rise_cyc, 32'd1);

    // Inter-byte timeout discards partial packet
    pkt_q.delete();
    send_byte(8'h04, -1, BYTE_CYC);
    send_byte(8'hAB, -1, BYTE_CYC);
    repeat (1100) @(negedge clk);
    check("to_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("to_cmd", {24'd0, cmd}, 32'h03);
    check("to_data", {16'd0, data}, 32'h8000);
    send_pkt(8'h06, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("to_count", pkt_q.size(), 32'd1);
    if (pkt_q.size() >= 1) check("to_pkt", {8'd0, pkt_q[0]}, 32'h060000);
    check("to_no_04", {31'd0, saw_cmd04}, 32'd0);

    // clr_cmd_rdy coincident with the load: set wins
    send_byte(8'h05, -1, BYTE_CYC);
    send_byte(8'h12, -1, BYTE_CYC);
    send_byte(8'h34, BYTE_CYC - 2, BYTE_CYC);
    repeat (2) @(negedge clk);
    check("setwin_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("setwin_cmd", {24'd0, cmd}, 32'h05);

    // Reset mid second byte
    send_byte(8'h02, -1, BYTE_CYC);
    send_byte(8'h55, -1, 150);
    rst_n = 1'b0;
    RX = 1'b1;
    #1;
    check("rst_mid_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_mid_cmd", {24'd0, cmd}, 32'h00);
    check("rst_mid_data", {16'd0, data}, 32'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_pkt(8'h07, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_after_cmd", {24'd0, cmd}, 32'h07);
    check("rst_after_data", {16'd0, data}, 32'h0000);
    check("rst_after_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Short glitch: receiver still completes a byte of all ones
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (340) @(negedge clk);
    check("glitch_counted", {31'd0, cmd_rdy}, 32'd0);
    check("glitch_cmd_kept", {24'd0, cmd}, 32'h07);
    send_byte(8'h00, -1, BYTE_CYC);
    send_byte(8'h01, -1, BYTE_CYC);
    repeat (2) @(negedge clk);
    check("glitch_pkt_cmd", {24'd0, cmd}, 32'hFF);
    check("glitch_pkt_data", {16'd0, data}, 32'h0001);
    check("glitch_pkt_rdy", {31'd0, cmd_rdy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
